fp_multiply_pipe: RTL

- Parametrised IEEE-754-style floating-point multiplier. Successor to the fixed single-precision multiplier.
- Adds the following:
  - configurable exponent and mantissa widths;
  - a 3-stage pipeline with valid/ready backpressure;
  - round-to-nearest-even;
  - special-value handling (zero, inf, NaN);
  - status flags.
- Sits between neural-network MAC datapaths and accumulators. It is used for single precision (8/23) and reduced formats (e.g. 5/10, 8/7).

---
 rtl/fp_multiply_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fp_multiply_pipe.sv
// Parametrised floating-point multiplier: 3-stage pipeline (classify, multiply,
// normalise/round/pack) with a shared enable for valid/ready backpressure.
module fp_multiply_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     c,
  output logic [3:0]       flags
);

  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS_S   = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX_S   = EW'(2**EXP_W - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // stage 1: unpack and classify
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == EXP_ONES) && (fa == '0);
  assign inf_b  = (eb == EXP_ONES) && (fb == '0);
  assign nan_a  = (ea == EXP_ONES) && (fa != '0);
  assign nan_b  = (eb == EXP_ONES) && (fb != '0);

  logic signed [EW-1:0] esum_d;
  assign esum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  logic                 v1_q, sign1_q, nan1_q, inf1_q, zero1_q;
  logic signed [EW-1:0] esum1_q;
  logic [MAN_W:0]       ma1_q, mb1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sign1_q <= a[W-1] ^ b[W-1];
      nan1_q  <= nan_a || nan_b;
      inf1_q  <= inf_a || inf_b;
      zero1_q <= zero_a || zero_b;
      esum1_q <= esum_d;
      ma1_q   <= {1'b1, fa};
      mb1_q   <= {1'b1, fb};
    end
  end

  // stage 2: significand product
  logic                 v2_q, sign2_q, nan2_q, inf2_q, zero2_q;
  logic signed [EW-1:0] esum2_q;
  logic [PW-1:0]        prod2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q <= 1'b0;
    end else if (en) begin
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sign2_q <= sign1_q;
      nan2_q  <= nan1_q;
      inf2_q  <= inf1_q;
      zero2_q <= zero1_q;
      esum2_q <= esum1_q;
      prod2_q <= PW'(ma1_q) * PW'(mb1_q);
    end
  end

  // stage 3: normalise, round to nearest even, pack
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     frac, frac_fin;
  logic                 guard, sticky, rnd_up;
  logic [MAN_W+1:0]     mant_r;
  logic signed [EW-1:0] exp_fin;
  logic [W-1:0]         c_d;
  logic [3:0]           flags_d;

  assign norm     = prod2_q[PW-1] ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
  assign frac     = norm[PW-2 -: MAN_W];
  assign guard    = norm[MAN_W];
  assign sticky   = |norm[MAN_W-1:0];
  assign rnd_up   = guard && (sticky || frac[0]);
  assign mant_r   = {2'b01, frac} + (MAN_W+2)'(rnd_up);
  assign frac_fin = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
  assign exp_fin  = esum2_q + $signed(EW'(prod2_q[PW-1])) + $signed(EW'(mant_r[MAN_W+1]));

  always_comb begin
    c_d     = {sign2_q, exp_fin[EXP_W-1:0], frac_fin};
    flags_d = {3'b000, guard || sticky};
    if (nan2_q || (inf2_q && zero2_q)) begin
      c_d     = QNAN;
      flags_d = 4'b1000;
    end else if (inf2_q) begin
      c_d     = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (zero2_q) begin
      c_d     = {sign2_q, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (exp_fin >= EMAX_S) begin
      c_d     = {sign2_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp_fin <= $signed(EW'(0))) begin
      c_d     = {sign2_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      c         <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= v2_q;
      if (v2_q) begin
        c     <= c_d;
        flags <= flags_d;
      end
    end
  end

endmodule
